// File: rtl/sram_alloc_pkg.sv
// Shared constants and types for the SRAM line allocator.
// The allocator top takes these as parameter defaults so a bench or an
// integration can shrink the bank count or capacity without editing the package.
package sram_alloc_pkg;

  localparam int NUM_SRAM       = 4;
  localparam int LINES_PER_SRAM = 2048;
  localparam int CNT_W          = 12;
  localparam int SRAM_ID_W      = 5;

  typedef logic [CNT_W-1:0]     credit_t;
  typedef logic [SRAM_ID_W-1:0] sram_id_t;

endpackage

// File: rtl/sram_line_allocator_rr_pick.sv
// Round-robin picker: returns the first set bit of eligible_i at or above
// rr_ptr_i, wrapping around to bit 0. Purely combinational.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Walk the banks starting at the pointer and latch the first eligible one.
  always_comb begin
    int pos;
    logic [IDX_W-1:0] cand;
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      pos = int'(rr_ptr_i) + off;
      if (pos >= N) begin
        pos = pos - N;
      end
      cand = IDX_W'(pos);
      if (!found_o && eligible_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/sram_line_allocator.sv
// Central line allocator: keeps a free-line credit per SRAM bank, hands out
// lines round-robin among banks with credit, and pulses the chosen bitmap.
// Credits come back one at a time through bitmap_add.
module sram_line_allocator #(
  parameter int NUM_SRAM       = sram_alloc_pkg::NUM_SRAM,
  parameter int LINES_PER_SRAM = sram_alloc_pkg::LINES_PER_SRAM,
  parameter int CNT_W          = sram_alloc_pkg::CNT_W,
  parameter int SRAM_ID_W      = sram_alloc_pkg::SRAM_ID_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRAM-1:0]  bitmap_add,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic [NUM_SRAM-1:0]  alloc_valid,
  output logic                 grant_valid,
  output logic [SRAM_ID_W-1:0] grant_sram_id,
  input  logic                 grant_ready,
  output logic [CNT_W+4:0]     free_total,
  output logic                 credit_err
);

  import sram_alloc_pkg::*;

  localparam int                PTR_W = $clog2(NUM_SRAM);
  localparam int                SUM_W = CNT_W + 5;
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(LINES_PER_SRAM);
  localparam logic [SUM_W-1:0]  TOTAL = SUM_W'(NUM_SRAM * LINES_PER_SRAM);

  logic [NUM_SRAM-1:0]  eligible;
  logic [NUM_SRAM-1:0]  alloc_sel;
  logic [NUM_SRAM-1:0]  sat_hit;
  logic [CNT_W-1:0]     credit [NUM_SRAM];

  logic                 pick_found;
  logic [PTR_W-1:0]     pick_idx;
  logic                 accept;

  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [SRAM_ID_W-1:0] grant_id_q, grant_id_d;
  logic [NUM_SRAM-1:0]  alloc_valid_q, alloc_valid_d;
  logic [SUM_W-1:0]     free_total_q, free_total_d;
  logic                 credit_err_q, credit_err_d;

  rr_pick #(
    .N     (NUM_SRAM),
    .IDX_W (PTR_W)
  ) u_rr_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  // Handshake, bank selection and grant/pulse next-state.
  always_comb begin
    req_ready     = pick_found && (!grant_valid_q || grant_ready);
    accept        = req_valid && req_ready;
    alloc_sel     = '0;
    rr_ptr_d      = rr_ptr_q;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    if (accept) begin
      alloc_sel     = NUM_SRAM'(1) << pick_idx;
      rr_ptr_d      = (pick_idx == PTR_W'(NUM_SRAM - 1)) ? '0 : pick_idx + 1'b1;
      grant_valid_d = 1'b1;
      grant_id_d    = SRAM_ID_W'(pick_idx);
    end else if (grant_ready) begin
      grant_valid_d = 1'b0;
    end
    alloc_valid_d = alloc_sel;
  end

  // One saturating credit counter per bank; a simultaneous alloc and return cancel.
  for (genvar gi = 0; gi < NUM_SRAM; gi++) begin : g_credit
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat;

    // Credit next-state: consume on alloc, replenish on return, flag a return at full.
    always_comb begin
      cnt_d = cnt_q;
      sat   = 1'b0;
      case ({alloc_sel[gi], bitmap_add[gi]})
        2'b10: cnt_d = cnt_q - 1'b1;
        2'b01: begin
          if (cnt_q == FULL) begin
            sat = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: cnt_d = cnt_q;
      endcase
    end

    // Credit register, refilled to full capacity on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= FULL;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign credit[gi]   = cnt_q;
    assign eligible[gi] = |cnt_q;
    assign sat_hit[gi]  = sat;
  end

  // Sum of the current credits (registered below, so it trails the counters by a cycle)
  // and the sticky overflow flag.
  always_comb begin
    free_total_d = '0;
    for (int i = 0; i < NUM_SRAM; i++) begin
      free_total_d = free_total_d + SUM_W'(credit[i]);
    end
    credit_err_d = credit_err_q | (|sat_hit);
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q      <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      alloc_valid_q <= '0;
      free_total_q  <= TOTAL;
      credit_err_q  <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      alloc_valid_q <= alloc_valid_d;
      free_total_q  <= free_total_d;
      credit_err_q  <= credit_err_d;
    end
  end

  assign alloc_valid   = alloc_valid_q;
  assign grant_valid   = grant_valid_q;
  assign grant_sram_id = grant_id_q;
  assign free_total    = free_total_q;
  assign credit_err    = credit_err_q;

endmodule

// File: tb/tb_sram_line_allocator.sv
// Directed bench for the line allocator with 4 banks of 4 lines each.
module tb_sram_line_allocator;

  logic        clk;
  logic        rst_n;
  logic [3:0]  bitmap_add;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  alloc_valid;
  logic        grant_valid;
  logic [4:0]  grant_sram_id;
  logic        grant_ready;
  logic [16:0] free_total;
  logic        credit_err;

  int checkCount;
  int errCount;

  sram_line_allocator #(
    .NUM_SRAM       (4),
    .LINES_PER_SRAM (4),
    .CNT_W          (12),
    .SRAM_ID_W      (5)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bitmap_add    (bitmap_add),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .alloc_valid   (alloc_valid),
    .grant_valid   (grant_valid),
    .grant_sram_id (grant_sram_id),
    .grant_ready   (grant_ready),
    .free_total    (free_total),
    .credit_err    (credit_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the requester and bitmap inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic rv, input logic gr, input logic [3:0] add);
    req_valid   = rv;
    grant_ready = gr;
    bitmap_add  = add;
    #1;
  endtask

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  initial begin
    checkCount  = 0;
    errCount    = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    grant_ready = 1'b1;
    bitmap_add  = 4'b0000;

    // Reset values.
    tick();
    tick();
    checkOutput("rst grant_valid", 32'(grant_valid), 0);
    checkOutput("rst alloc_valid", 32'(alloc_valid), 0);
    checkOutput("rst grant_id", 32'(grant_sram_id), 0);
    checkOutput("rst free_total", 32'(free_total), 16);
    checkOutput("rst credit_err", 32'(credit_err), 0);
    checkOutput("rst req_ready", 32'(req_ready), 1);
    rst_n = 1'b1;

    // Four back-to-back accepts walk banks 0..3.
    applyStimulus(1'b1, 1'b1, 4'b0000);
    for (int n = 0; n < 4; n++) begin
      tick();
      checkOutput("rr grant_id", 32'(grant_sram_id), 32'(n));
      checkOutput("rr grant_valid", 32'(grant_valid), 1);
      checkOutput("rr alloc_valid", 32'(alloc_valid), 32'(1) << n);
    end
    applyStimulus(1'b0, 1'b1, 4'b0000);
    tick();
    tick();
    checkOutput("rr free_total", 32'(free_total), 12);
    checkOutput("rr grant idle", 32'(grant_valid), 0);

    // Drain the remaining 12 credits.
    applyStimulus(1'b1, 1'b1, 4'b0000);
    for (int n = 0; n < 12; n++) begin
      tick();
      checkOutput("drain grant_id", 32'(grant_sram_id), 32'(n % 4));
    end
    checkOutput("empty req_ready", 32'(req_ready), 0);
    tick();
    checkOutput("empty alloc_valid", 32'(alloc_valid), 0);
    checkOutput("empty grant_valid", 32'(grant_valid), 0);
    checkOutput("empty free_total", 32'(free_total), 0);

    // A single return to bank 2 makes it the only eligible bank.
    applyStimulus(1'b0, 1'b1, 4'b0100);
    checkOutput("add same-cycle req_ready", 32'(req_ready), 0);
    tick();
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("add req_ready", 32'(req_ready), 1);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    tick();
    checkOutput("refill grant_id", 32'(grant_sram_id), 2);
    checkOutput("refill alloc_valid", 32'(alloc_valid), 4);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    tick();

    // Fresh start; every alloc coincides with a return except for bank 1, which drains.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int n = 0; n < 16; n++) begin
      applyStimulus(1'b1, 1'b1, (n % 4 == 1) ? 4'b0000 : (4'b0001 << (n % 4)));
      tick();
      checkOutput("cancel grant_id", 32'(grant_sram_id), 32'(n % 4));
    end
    checkOutput("cancel credit_err", 32'(credit_err), 0);
    applyStimulus(1'b1, 1'b1, 4'b0001);
    tick();
    checkOutput("skip pre grant_id", 32'(grant_sram_id), 0);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    tick();
    checkOutput("skip empty bank1", 32'(grant_sram_id), 2);
    tick();
    checkOutput("skip ptr to 3", 32'(grant_sram_id), 3);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    tick();
    tick();
    checkOutput("skip free_total", 32'(free_total), 10);
    checkOutput("skip credit_err", 32'(credit_err), 0);

    // Grant back-pressure: grant holds and no further accepts until grant_ready.
    applyStimulus(1'b1, 1'b0, 4'b0000);
    checkOutput("bp req_ready idle", 32'(req_ready), 1);
    tick();
    checkOutput("bp grant_valid", 32'(grant_valid), 1);
    checkOutput("bp grant_id", 32'(grant_sram_id), 0);
    checkOutput("bp alloc_valid", 32'(alloc_valid), 1);
    checkOutput("bp req_ready held", 32'(req_ready), 0);
    for (int n = 0; n < 2; n++) begin
      tick();
      checkOutput("bp hold alloc_valid", 32'(alloc_valid), 0);
      checkOutput("bp hold grant_valid", 32'(grant_valid), 1);
      checkOutput("bp hold grant_id", 32'(grant_sram_id), 0);
    end
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("bp release req_ready", 32'(req_ready), 1);
    tick();
    checkOutput("bp next grant_id", 32'(grant_sram_id), 2);
    checkOutput("bp next alloc_valid", 32'(alloc_valid), 4);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    tick();
    checkOutput("bp grant cleared", 32'(grant_valid), 0);

    // Bank 3 refills to full, then one more return overflows.
    applyStimulus(1'b0, 1'b1, 4'b1000);
    tick();
    checkOutput("fill credit_err", 32'(credit_err), 0);
    tick();
    checkOutput("overflow credit_err", 32'(credit_err), 1);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    tick();
    tick();
    checkOutput("overflow free_total", 32'(free_total), 9);
    checkOutput("overflow sticky", 32'(credit_err), 1);

    // Reset in the middle of an outstanding grant.
    applyStimulus(1'b1, 1'b0, 4'b0000);
    tick();
    checkOutput("mid grant_valid", 32'(grant_valid), 1);
    checkOutput("mid grant_id", 32'(grant_sram_id), 3);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async grant_valid", 32'(grant_valid), 0);
    checkOutput("async alloc_valid", 32'(alloc_valid), 0);
    checkOutput("async credit_err", 32'(credit_err), 0);
    checkOutput("async free_total", 32'(free_total), 16);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("post-rst free_total", 32'(free_total), 16);
    checkOutput("post-rst req_ready", 32'(req_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
    $finish;
  end

endmodule

// File: doc/sram_line_allocator.md
Name: sram_line_allocator

Overview:
- Central allocator on the request side of the per-SRAM free-line bitmaps.
- Tracks a free-line credit count for each of NUM_SRAM SRAM banks. Counts are replenished by each bitmap's bitmap_add return pulses and consumed by allocations.
- Serves line-allocation requests from the cache controller over a valid/ready handshake. Picks a bank round-robin among banks with credit.
- Drives the one-hot alloc_valid pulse back to the chosen bitmap.

Parameters:
- NUM_SRAM, 4, number of SRAM banks / bitmap instances (2..32).
- LINES_PER_SRAM, 2048, credit capacity per bank; reset value of each counter.
- CNT_W, 12, credit counter width; must hold LINES_PER_SRAM.
- SRAM_ID_W, 5, width of the bank id returned to the requester.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- bitmap_add  in  NUM_SRAM  per-bank one-cycle line-return pulse, one bit per bitmap
- req_valid  in  1  allocation request
- req_ready  out  1  allocator can accept a request this cycle
- alloc_valid  out  NUM_SRAM  one-hot, one-cycle allocation pulse to the selected bitmap
- grant_valid  out  1  grant result available
- grant_sram_id  out  SRAM_ID_W  index of the granted bank
- grant_ready  in  1  requester consumes the grant
- free_total  out  CNT_W+5  sum of all bank credits, registered
- credit_err  out  1  sticky: a return arrived at a full bank

Behaviour:
- Reset is rst_n, asynchronous, active-low; the clock is clk.
- Reset values:
  - every credit counter = LINES_PER_SRAM
  - rr_ptr = 0
  - alloc_valid = 0, grant_valid = 0, grant_sram_id = 0
  - free_total = NUM_SRAM*LINES_PER_SRAM
  - credit_err = 0
- Eligible bank: credit > 0.
- Selection: first eligible bank at or after rr_ptr, scanning upward with wrap to 0. This is combinational from the current credits.
- req_ready = (any bank eligible) && (!grant_valid || grant_ready). req_ready does not depend on req_valid.
- Accept edge T: req_valid && req_ready.
  - The selected bank k's credit decrements at edge T.
  - rr_ptr <= (k+1) mod NUM_SRAM.
  - grant_valid <= 1 and grant_sram_id <= k.
  - alloc_valid <= one-hot(k).
  - Latency from accept to alloc_valid/grant_valid is 1 cycle.
- alloc_valid is high for exactly one cycle per accepted request. It clears the next cycle unless another request is accepted.
- grant_valid holds, with grant_sram_id stable, until grant_ready.
- Back-to-back operation: with grant_ready held at 1, one request per cycle is accepted.
- Credit update per bank per cycle:
  - alloc and no add: -1
  - add and no alloc: +1
  - both: unchanged
  - neither: unchanged
- Saturation: an add to a bank already at LINES_PER_SRAM leaves the count unchanged and sets credit_err. credit_err clears only on reset.
- Underflow cannot occur: only eligible banks are selected.
- free_total: registered sum of the post-update credits, one cycle behind the counters.
- All banks at 0: req_ready = 0; rr_ptr holds. A later bitmap_add makes that bank eligible on the next cycle.
- Reset mid-operation: an in-flight grant is dropped, alloc_valid returns to 0 immediately, and all credits return to full.
- A bitmap_add that coincides with reset is lost.

Decomposition:
- Package sram_alloc_pkg holds:
  - NUM_SRAM, LINES_PER_SRAM, CNT_W, SRAM_ID_W
  - typedef credit_t (CNT_W bits)
  - typedef sram_id_t (SRAM_ID_W bits)
- Sub-module rr_pick: pure combinational round-robin picker.
  - Inputs: eligible vector, rr_ptr.
  - Outputs: found, idx.
- Credit counters are a generate loop in the top module.

Test Plan (NUM_SRAM=4, LINES_PER_SRAM=4 unless noted):
- Reset then req_valid held 1, grant_ready=1 for 4 cycles:
  - grant_sram_id sequence 0,1,2,3
  - alloc_valid sequence 0001,0010,0100,1000, each 1 cycle after accept
  - free_total goes 16→12
- 16 accepts, no returns:
  - all credits 0, req_ready=0, free_total=0
  - then bitmap_add=0100 for 1 cycle → next accept grants bank 2 and alloc_valid=0100
- Bank 1 driven to credit 0, then request with rr_ptr=1 → bank 1 is skipped and bank 2 is granted; rr_ptr becomes 3.
- Bank 0 at credit 2, alloc to bank 0 with bitmap_add[0]=1 on the same cycle → credit stays 2 and credit_err stays 0.
- grant_ready=0 for 3 cycles after an accept:
  - grant_valid and grant_sram_id hold
  - req_ready=0 and no second alloc_valid pulse
  - grant_ready=1 → the next request is accepted in the same cycle
- Overflow and reset:
  - bitmap_add[3]=1 at full credit → credit stays 4, credit_err=1
  - assert rst_n=0 mid-grant → grant_valid, alloc_valid and credit_err = 0 asynchronously; credits all 4
